// File: rtl/ctrl_seq_pkg.sv
// Shared types and helpers for the opcode sequencer: state encoding,
// the NOP opcode and the opcode-to-control decode equations.
package ctrl_seq_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        WAIT   = 3'd3,
        WB     = 3'd4,
        ERR    = 3'd5
    } state_e;

    localparam logic [2:0] OPCODE_NOP = 3'b000;

    typedef struct packed {
        logic       alu_op;
        logic [1:0] wb_sel;
    } decode_t;

    // Maps a 3-bit opcode onto the ALU operation and register-destination select.
    function automatic decode_t ctrl_decode(input logic [2:0] op);
        decode_t d;
        logic    s0;
        logic    s1;
        s0       = (op[0] & ~op[1]) | (op[2] & op[1]);
        s1       = ~op[2] & op[0];
        d.wb_sel = {s1, s0};
        d.alu_op = s0 & ~s1;
        return d;
    endfunction

endpackage

// File: rtl/ctrl_seq_fsm_if.sv
// Instruction-source / ALU / register-file signal bundle of the sequencer.
// The slave modport is the sequencer's view; master is the surrounding datapath.
interface ctrl_seq_fsm_if #(
    parameter int OPW  = 3,
    parameter int CNTW = 8
);
    logic            instr_valid;
    logic            instr_ready;
    logic [OPW-1:0]  instr_opcode;
    logic            alu_start;
    logic            alu_op;
    logic            alu_done;
    logic            wb_en;
    logic [1:0]      wb_sel;
    logic            busy;
    logic            timeout_err;
    logic            err_clr;
    logic [CNTW-1:0] retired_cnt;

    modport master (
        output instr_valid, instr_opcode, alu_done, err_clr,
        input  instr_ready, alu_start, alu_op, wb_en, wb_sel, busy,
               timeout_err, retired_cnt
    );

    modport slave (
        input  instr_valid, instr_opcode, alu_done, err_clr,
        output instr_ready, alu_start, alu_op, wb_en, wb_sel, busy,
               timeout_err, retired_cnt
    );
endinterface

// File: rtl/ctrl_seq_timer.sv
// Wait-cycle counter for the ALU completion timeout. Cleared before each
// wait, advanced once per idle wait cycle; expired flags the last allowed cycle.
module ctrl_seq_timer #(
    parameter int TIMEOUT = 8,
    localparam int W      = $clog2(TIMEOUT + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [W-1:0] cnt_q;

    // Count consecutive wait cycles; clear has priority over enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= cnt_q + W'(1);
        end
    end

    // The count equals the number of waits already elapsed, so TIMEOUT-1
    // marks the final cycle in which alu_done can still be accepted.
    assign expired = (cnt_q == W'(TIMEOUT - 1));

endmodule

// File: rtl/ctrl_seq_fsm.sv
// Multi-cycle instruction sequencer: accepts an opcode, decodes it, launches
// the ALU, waits for completion under a timeout and strobes the writeback.
module ctrl_seq_fsm
    import ctrl_seq_pkg::*;
#(
    parameter int OPW     = 3,
    parameter int TIMEOUT = 8,
    parameter int CNTW    = 8
) (
    input logic           clk,
    input logic           rst_n,
    ctrl_seq_fsm_if.slave bus
);

    localparam logic [2:0] ST_IDLE   = IDLE;
    localparam logic [2:0] ST_DECODE = DECODE;
    localparam logic [2:0] ST_EXEC   = EXEC;
    localparam logic [2:0] ST_WAIT   = WAIT;
    localparam logic [2:0] ST_WB     = WB;
    localparam logic [2:0] ST_ERR    = ERR;

    logic [2:0]      state_q;
    logic [2:0]      state_d;
    logic [OPW-1:0]  opcode_q;
    logic            alu_op_q;
    logic [1:0]      wb_sel_q;
    logic [CNTW-1:0] retired_q;
    logic            retire;
    logic            tmr_clr;
    logic            tmr_en;
    logic            tmr_expired;
    decode_t         dec;

    assign dec = ctrl_decode(opcode_q);

    ctrl_seq_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (tmr_clr),
        .en      (tmr_en),
        .expired (tmr_expired)
    );

    // Next-state logic; alu_done and err_clr only matter in their own states.
    always_comb begin
        state_d = state_q;
        retire  = 1'b0;
        tmr_clr = 1'b0;
        tmr_en  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.instr_valid) state_d = ST_DECODE;
            end
            ST_DECODE: begin
                if (opcode_q == OPCODE_NOP) begin
                    retire  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                tmr_clr = 1'b1;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (bus.alu_done) begin
                    if (wb_sel_q != 2'b00) begin
                        state_d = ST_WB;
                    end else begin
                        retire  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end else if (tmr_expired) begin
                    state_d = ST_ERR;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            ST_WB: begin
                retire  = 1'b1;
                state_d = ST_IDLE;
            end
            ST_ERR: begin
                if (bus.err_clr) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Capture the opcode on the accepting handshake only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opcode_q <= '0;
        end else if (state_q == ST_IDLE && bus.instr_valid) begin
            opcode_q <= bus.instr_opcode;
        end
    end

    // Decoded controls are registered in DECODE and held until the next decode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_op_q <= 1'b0;
            wb_sel_q <= 2'b00;
        end else if (state_q == ST_DECODE) begin
            alu_op_q <= dec.alu_op;
            wb_sel_q <= dec.wb_sel;
        end
    end

    // Retired-instruction counter, wraps silently.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      retired_q <= '0;
        else if (retire) retired_q <= retired_q + CNTW'(1);
    end

    assign bus.instr_ready  = (state_q == ST_IDLE);
    assign bus.busy         = (state_q != ST_IDLE);
    assign bus.alu_start    = (state_q == ST_EXEC);
    assign bus.wb_en        = (state_q == ST_WB);
    assign bus.timeout_err  = (state_q == ST_ERR);
    assign bus.alu_op       = alu_op_q;
    assign bus.wb_sel       = wb_sel_q;
    assign bus.retired_cnt  = retired_q;

endmodule

// File: tb/tb_ctrl_seq_fsm.sv
// Bench for ctrl_seq_fsm: directed vector table, hand sequences for reset and
// counter wrap, and randomized transactions against a transaction-level model.
module tb_ctrl_seq_fsm;

    localparam int TO = 8;

    logic clk;
    logic rst_n;

    ctrl_seq_fsm_if #(.OPW(3), .CNTW(8)) bus ();
    ctrl_seq_fsm_if #(.OPW(3), .CNTW(2)) bus2 ();

    ctrl_seq_fsm #(.OPW(3), .TIMEOUT(TO), .CNTW(8)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // Second instance with a 2-bit counter runs in lockstep on the same inputs.
    ctrl_seq_fsm #(.OPW(3), .TIMEOUT(TO), .CNTW(2)) u_dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2.slave)
    );

    assign bus2.instr_valid  = bus.instr_valid;
    assign bus2.instr_opcode = bus.instr_opcode;
    assign bus2.alu_done     = bus.alu_done;
    assign bus2.err_clr      = bus.err_clr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    int unsigned model_cnt = 0;

    typedef struct {
        logic [2:0] op;
        int         d;
        logic       exp_alu;
        logic [1:0] exp_sel;
    } vec_t;

    vec_t vecs [8];
    int   exp2 [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic rb(input logic en);
        return en ? 1'($urandom_range(0, 1)) : 1'b0;
    endfunction

    // Hand-derived opcode decode table: {alu_op, wb_sel}.
    function automatic logic [2:0] ref_decode(input logic [2:0] op);
        case (op)
            3'd0: return 3'b0_00;
            3'd1: return 3'b0_11;
            3'd2: return 3'b0_00;
            3'd3: return 3'b0_10;
            3'd4: return 3'b0_00;
            3'd5: return 3'b1_01;
            3'd6: return 3'b1_01;
            default: return 3'b1_01;
        endcase
    endfunction

    task automatic chk_state(input string tag, input logic r, input logic b,
                             input logic s, input logic w, input logic e);
        logic [31:0] exp;
        logic [7:0]  mc8;
        logic [1:0]  mc2;
        mc8 = model_cnt[7:0];
        mc2 = model_cnt[1:0];
        exp = {27'd0, r, b, s, w, e};
        check({tag, "_ctl"}, {27'd0, bus.instr_ready, bus.busy, bus.alu_start,
                              bus.wb_en, bus.timeout_err}, exp);
        check({tag, "_ctl2"}, {27'd0, bus2.instr_ready, bus2.busy, bus2.alu_start,
                               bus2.wb_en, bus2.timeout_err}, exp);
        check({tag, "_cnt"}, {24'd0, bus.retired_cnt}, {24'd0, mc8});
        check({tag, "_cnt2"}, {30'd0, bus2.retired_cnt}, {30'd0, mc2});
    endtask

    task automatic chk_dec(input string tag, input logic ea, input logic [1:0] es);
        check({tag, "_dec"}, {29'd0, bus.alu_op, bus.wb_sel}, {29'd0, ea, es});
    endtask

    // One instruction from the IDLE cycle in which it is offered. d is the
    // WAIT cycle carrying alu_done; d > TO means the ALU never answers.
    task automatic run_instr(input string tag, input logic [2:0] op, input int d,
                             input logic ea, input logic [1:0] es, input logic nz);
        logic done_seen;
        int   n;
        chk_state({tag, "_c0"}, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        bus.instr_valid  = 1'b1;
        bus.instr_opcode = op;
        bus.alu_done     = rb(nz);
        bus.err_clr      = rb(nz);
        step();
        chk_state({tag, "_c1"}, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        bus.instr_valid = rb(nz);
        if (nz) bus.instr_opcode = 3'($urandom_range(0, 7));
        bus.alu_done = rb(nz);
        bus.err_clr  = rb(nz);
        step();
        if (op == 3'b000) begin
            model_cnt++;
            bus.instr_valid = 1'b0;
            bus.alu_done    = 1'b0;
            bus.err_clr     = 1'b0;
            return;
        end
        chk_state({tag, "_c2"}, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        chk_dec({tag, "_c2"}, ea, es);
        bus.instr_valid = rb(nz);
        bus.alu_done    = rb(nz);
        bus.err_clr     = rb(nz);
        step();
        done_seen = 1'b0;
        for (int w = 1; w <= TO; w++) begin
            chk_state($sformatf("%s_w%0d", tag, w), 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
            chk_dec($sformatf("%s_w%0d", tag, w), ea, es);
            bus.alu_done    = (w == d);
            bus.instr_valid = rb(nz);
            bus.err_clr     = rb(nz);
            step();
            if (w == d) begin
                done_seen = 1'b1;
                break;
            end
        end
        bus.instr_valid = 1'b0;
        if (done_seen) begin
            if (es != 2'b00) begin
                chk_state({tag, "_wb"}, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
                chk_dec({tag, "_wb"}, ea, es);
                bus.alu_done = rb(nz);
                bus.err_clr  = rb(nz);
                step();
            end
            model_cnt++;
        end else begin
            n = nz ? int'($urandom_range(1, 3)) : 1;
            for (int k = 0; k < n; k++) begin
                chk_state($sformatf("%s_err%0d", tag, k), 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
                bus.alu_done = (k == 0) ? 1'b1 : rb(nz);
                bus.err_clr  = 1'b0;
                step();
            end
            chk_state({tag, "_errclr"}, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
            bus.alu_done = rb(nz);
            bus.err_clr  = 1'b1;
            step();
        end
        bus.alu_done = 1'b0;
        bus.err_clr  = 1'b0;
    endtask

    task automatic idle_gap(input int n, input logic nz);
        for (int i = 0; i < n; i++) begin
            chk_state("gap", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            bus.instr_valid = 1'b0;
            bus.alu_done    = rb(nz);
            bus.err_clr     = rb(nz);
            step();
        end
        bus.alu_done = 1'b0;
        bus.err_clr  = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] dv;
        logic [2:0] rop;

        vecs[0] = '{op: 3'b110, d: 1,      exp_alu: 1'b1, exp_sel: 2'b01};
        vecs[1] = '{op: 3'b001, d: 3,      exp_alu: 1'b0, exp_sel: 2'b11};
        vecs[2] = '{op: 3'b010, d: 1,      exp_alu: 1'b0, exp_sel: 2'b00};
        vecs[3] = '{op: 3'b101, d: TO + 1, exp_alu: 1'b1, exp_sel: 2'b01};
        vecs[4] = '{op: 3'b111, d: TO,     exp_alu: 1'b1, exp_sel: 2'b01};
        vecs[5] = '{op: 3'b011, d: 2,      exp_alu: 1'b0, exp_sel: 2'b10};
        vecs[6] = '{op: 3'b100, d: 4,      exp_alu: 1'b0, exp_sel: 2'b00};
        vecs[7] = '{op: 3'b000, d: 0,      exp_alu: 1'b0, exp_sel: 2'b00};
        exp2    = '{1, 2, 3, 0, 1};

        bus.instr_valid  = 1'b0;
        bus.instr_opcode = 3'b000;
        bus.alu_done     = 1'b0;
        bus.err_clr      = 1'b0;
        rst_n            = 1'b1;
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_state("rst", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_dec("rst", 1'b0, 2'b00);
        @(negedge clk) rst_n = 1'b1;
        step();

        // Back-to-back NOPs: two cycles each, 2-bit counter wraps 3 -> 0.
        for (int i = 0; i < 5; i++) begin
            run_instr($sformatf("nop%0d", i), 3'b000, 0, 1'b0, 2'b00, 1'b0);
            check($sformatf("nop%0d_cnt2seq", i), {30'd0, bus2.retired_cnt}, exp2[i]);
            if (i == 3) check("nop4_cnt", {24'd0, bus.retired_cnt}, 32'd4);
        end

        // Directed vectors, issued back to back.
        for (int i = 0; i < 8; i++) begin
            run_instr($sformatf("v%0d", i), vecs[i].op, vecs[i].d,
                      vecs[i].exp_alu, vecs[i].exp_sel, 1'b0);
        end

        // Reset asserted between edges while waiting on the ALU.
        chk_state("rw_c0", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        bus.instr_valid  = 1'b1;
        bus.instr_opcode = 3'b110;
        step();
        bus.instr_valid = 1'b0;
        step();
        step();
        step();
        chk_state("rw_wait", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        model_cnt = 0;
        chk_state("rw_rst", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_dec("rw_rst", 1'b0, 2'b00);
        @(negedge clk) rst_n = 1'b1;
        bus.alu_done = 1'b1;
        step();
        for (int i = 0; i < 3; i++) begin
            chk_state($sformatf("rw_after%0d", i), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            step();
        end
        bus.alu_done = 1'b0;

        // Randomized transactions with ignored-input noise.
        for (int i = 0; i < 150; i++) begin
            rop = 3'($urandom_range(0, 7));
            dv  = ref_decode(rop);
            run_instr($sformatf("r%0d", i), rop, int'($urandom_range(1, TO + 2)),
                      dv[2], dv[1:0], 1'b1);
            idle_gap(int'($urandom_range(0, 2)), 1'b1);
        end

        chk_state("end", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
